// File: rtl/rat_pkg.sv
// rat_pkg: shared state encoding, direction codes and maze limits for the rat controller
package rat_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        MARK,
        CHECK,
        BACK,
        NEXT,
        DONE,
        FAIL
    } state_t;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    localparam logic [3:0] MAZE_MAX = 4'hF;

    // Reversing a move only flips the axis-sign bit of the direction code
    function automatic logic [1:0] opposite(input logic [1:0] d);
        return d ^ 2'b10;
    endfunction

endpackage

// File: rtl/rat_dir_decode.sv
// rat_dir_decode: maps a direction code to the neighbour-address selects
module rat_dir_decode
    import rat_pkg::*;
(
    input  logic [1:0] dir,
    output logic [3:0] sel
);

    // sel = {adder_sel, inc_dec_sel, x_sel, y_sel}; horizontal moves steer the adder onto x
    always_comb begin
        sel = (dir == DIR_UP)    ? 4'b0001 :
              (dir == DIR_RIGHT) ? 4'b1110 :
              (dir == DIR_DOWN)  ? 4'b0101 : 4'b1010;
    end

endmodule

// File: rtl/rat_controller.sv
// rat_controller: depth-first search control FSM driving the rat datapath strobes
module rat_controller
    import rat_pkg::*;
#(
    parameter int            TW         = 16,
    parameter logic [TW-1:0] MAX_CYCLES = 16'd65535
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       co,
    input  logic [1:0] counter_val,
    input  logic [1:0] pop_val,
    input  logic       empty,
    input  logic       wall,
    input  logic       finish,
    output logic       rst_reg,
    output logic       rst_counter,
    output logic       ld_reg,
    output logic       ld_counter,
    output logic       inc_counter,
    output logic       adder_sel,
    output logic       inc_dec_sel,
    output logic       x_sel,
    output logic       y_sel,
    output logic       pop,
    output logic       push,
    output logic       rd_mem,
    output logic       wr_mem,
    output logic       mem_din,
    output logic [1:0] push_val,
    output logic [1:0] counter_ld_val,
    output logic       done,
    output logic       fail
);

    localparam logic [TW-1:0] WD_LAST = MAX_CYCLES - TW'(1);

    state_t        state;
    logic [TW-1:0] wd;
    logic          busy;
    logic          wd_hit;
    logic          probe;
    logic [1:0]    dir;
    logic [3:0]    dec;

    assign busy   = !(state inside {IDLE, DONE, FAIL});
    assign wd_hit = busy && (wd == WD_LAST);
    assign done   = (state == DONE);
    assign fail   = (state == FAIL);

    // Backtracking steps opposite to the popped move; everything else probes the counter direction
    assign dir = (state == BACK) ? opposite(pop_val) : counter_val;

    rat_dir_decode u_dec (
        .dir (dir),
        .sel (dec)
    );

    assign {adder_sel, inc_dec_sel, x_sel, y_sel} = probe ? dec : 4'b0000;

    // Per-cycle datapath strobes; a watchdog hit silences everything for its cycle
    always_comb begin
        {rst_reg, rst_counter, ld_reg, ld_counter, inc_counter} = '0;
        {pop, push, rd_mem, wr_mem, mem_din} = '0;
        push_val       = '0;
        counter_ld_val = '0;
        probe          = 1'b0;
        if (!wd_hit) begin
            case (state)
                INIT: {rst_reg, rst_counter} = 2'b11;
                MARK: {wr_mem, mem_din} = 2'b11;
                CHECK: if (!finish) begin
                    rd_mem      = 1'b1;
                    probe       = 1'b1;
                    inc_counter = wall && !co;
                    ld_reg      = !wall;
                    push        = !wall;
                    rst_counter = !wall;
                    push_val    = wall ? 2'b00 : counter_val;
                end
                BACK: if (!empty) begin
                    {pop, ld_reg, ld_counter, probe} = 4'b1111;
                    counter_ld_val = pop_val;
                end
                NEXT: inc_counter = !co;
                default: ;
            endcase
        end
    end

    // State register and busy-cycle watchdog, which idles at zero so each run counts from INIT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            wd    <= '0;
        end else begin
            wd <= busy ? wd + TW'(1) : '0;
            if (wd_hit)
                state <= FAIL;
            else
                case (state)
                    IDLE, DONE, FAIL: if (start) state <= INIT;
                    INIT:    state <= MARK;
                    MARK:    state <= CHECK;
                    CHECK:   state <= finish ? DONE : !wall ? MARK : co ? BACK : CHECK;
                    BACK:    state <= empty ? FAIL : NEXT;
                    NEXT:    state <= co ? BACK : CHECK;
                    default: state <= IDLE;
                endcase
        end
    end

endmodule

// File: tb/tb_rat_controller.sv
// tb_rat_controller: directed maze runs against a behavioural datapath with a push/pop scoreboard
module tb_rat_controller;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic start_w = 1'b0;
    logic load = 1'b0;
    logic [255:0] walls = '0;

    logic co, empty, wall, finish;
    logic [1:0] counter_val, pop_val;
    logic rst_reg, rst_counter, ld_reg, ld_counter, inc_counter;
    logic adder_sel, inc_dec_sel, x_sel, y_sel;
    logic pop, push, rd_mem, wr_mem, mem_din;
    logic [1:0] push_val, counter_ld_val;
    logic done, fail;
    logic [19:0] so;

    logic [17:0] sw;
    logic done_w, fail_w;

    logic [3:0] x = '0, y = '0;
    logic [1:0] cnt = '0;
    logic [8:0] sp = '0;
    logic [1:0] stk [0:255];
    logic [255:0] mem = '1;
    logic [4:0] ax, ay;

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int n_push = 0, n_pop = 0, n_rd = 0, n_rstreg = 0;
    logic [1:0] exp_push [$];
    logic [1:0] exp_pop [$];

    always #5 clk = ~clk;

    rat_controller dut (
        .clk(clk), .rst(rst), .start(start), .co(co), .counter_val(counter_val),
        .pop_val(pop_val), .empty(empty), .wall(wall), .finish(finish),
        .rst_reg(rst_reg), .rst_counter(rst_counter), .ld_reg(ld_reg), .ld_counter(ld_counter),
        .inc_counter(inc_counter), .adder_sel(adder_sel), .inc_dec_sel(inc_dec_sel),
        .x_sel(x_sel), .y_sel(y_sel), .pop(pop), .push(push), .rd_mem(rd_mem),
        .wr_mem(wr_mem), .mem_din(mem_din), .push_val(push_val),
        .counter_ld_val(counter_ld_val), .done(done), .fail(fail)
    );

    // Endless open corridor: every probe is free, so only the watchdog can stop it
    rat_controller #(.MAX_CYCLES(16'd20)) dut_w (
        .clk(clk), .rst(rst), .start(start_w), .co(1'b0), .counter_val(2'b00),
        .pop_val(2'b00), .empty(1'b0), .wall(1'b0), .finish(1'b0),
        .rst_reg(sw[0]), .rst_counter(sw[1]), .ld_reg(sw[2]), .ld_counter(sw[3]),
        .inc_counter(sw[4]), .adder_sel(sw[5]), .inc_dec_sel(sw[6]),
        .x_sel(sw[7]), .y_sel(sw[8]), .pop(sw[9]), .push(sw[10]), .rd_mem(sw[11]),
        .wr_mem(sw[12]), .mem_din(sw[13]), .push_val(sw[15:14]),
        .counter_ld_val(sw[17:16]), .done(done_w), .fail(fail_w)
    );

    assign so = {rst_reg, rst_counter, ld_reg, ld_counter, inc_counter, adder_sel, inc_dec_sel,
                 x_sel, y_sel, pop, push, rd_mem, wr_mem, mem_din, push_val, counter_ld_val, done, fail};

    // Behavioural datapath: position, direction counter, move stack and maze/visited memory
    assign ax = (adder_sel && x_sel) ? (inc_dec_sel ? {1'b0, x} + 5'd1 : {1'b0, x} - 5'd1) : {1'b0, x};
    assign ay = (!adder_sel && y_sel) ? (inc_dec_sel ? {1'b0, y} + 5'd1 : {1'b0, y} - 5'd1) : {1'b0, y};
    assign wall = ax[4] | ay[4] | mem[{ay[3:0], ax[3:0]}];
    assign finish = (x == 4'hF) && (y == 4'hF);
    assign counter_val = cnt;
    assign co = (cnt == 2'b11);
    assign empty = (sp == 9'd0);
    assign pop_val = stk[8'(sp - 9'd1)];

    always @(posedge clk) begin
        if (load) mem <= walls;
        else if (wr_mem) mem[{y, x}] <= mem_din;
        if (rst_reg) begin
            x <= '0;
            y <= '0;
            sp <= '0;
        end else begin
            if (ld_reg) begin
                x <= ax[3:0];
                y <= ay[3:0];
            end
            if (push) begin
                stk[sp[7:0]] <= push_val;
                sp <= sp + 9'd1;
            end
            if (pop) sp <= sp - 9'd1;
        end
        if (rst_counter) cnt <= '0;
        else if (ld_counter) cnt <= counter_ld_val;
        else if (inc_counter) cnt <= cnt + 2'd1;
    end

    function automatic logic [3:0] dec(input logic [1:0] d);
        case (d)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b1110;
            2'b10:   return 4'b0101;
            default: return 4'b1010;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        logic [1:0] e;
        @(posedge clk);
        #1;
        if (rst_reg) n_rstreg++;
        if (rd_mem) n_rd++;
        if (push) begin
            n_push++;
            chk("push_expected", 32'(exp_push.size() > 0), 32'd1);
            if (exp_push.size() > 0) begin
                e = exp_push.pop_front();
                chk("push_val", 32'(push_val), 32'(e));
                chk("move_decode", 32'({adder_sel, inc_dec_sel, x_sel, y_sel}), 32'(dec(e)));
                chk("move_strobes", 32'({ld_reg, rst_counter, rd_mem, pop}), 32'b1110);
            end
        end
        if (pop) begin
            n_pop++;
            chk("pop_expected", 32'(exp_pop.size() > 0), 32'd1);
            if (exp_pop.size() > 0) begin
                e = exp_pop.pop_front();
                chk("counter_ld_val", 32'(counter_ld_val), 32'(e));
                chk("back_decode", 32'({adder_sel, inc_dec_sel, x_sel, y_sel}), 32'(dec(e ^ 2'b10)));
                chk("back_strobes", 32'({pop, ld_reg, ld_counter, push}), 32'b1110);
            end
        end
    endtask

    task automatic load_maze(input logic [255:0] w);
        walls = w;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic go_idle();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic begin_run();
        n_push = 0;
        n_pop = 0;
        n_rd = 0;
        n_rstreg = 0;
        start = 1'b1;
        tick();
    endtask

    task automatic run_to_end(input int lim);
        int n = 0;
        while (!(done || fail) && n < lim) begin
            tick();
            n++;
        end
    endtask

    task automatic fill_open();
        exp_push.delete();
        exp_pop.delete();
        for (int i = 0; i < 15; i++) exp_push.push_back(2'b01);
        for (int i = 0; i < 15; i++) exp_push.push_back(2'b10);
    endtask

    initial begin
        int n;
        logic [17:0] s18, s19;
        logic [255:0] w;

        // Reset state
        tick();
        tick();
        chk("reset_outputs", 32'(so), 32'd0);
        chk("reset_wd_outputs", 32'({sw, done_w, fail_w}), 32'd0);
        rst = 1'b1;
        tick();
        chk("idle_outputs", 32'(so), 32'd0);

        // Open maze: INIT, MARK, first up probe, then straight right and down to (15,15)
        load_maze('0);
        fill_open();
        begin_run();
        start = 1'b0;
        chk("init_strobes", 32'({rst_reg, rst_counter, wr_mem, rd_mem}), 32'b1100);
        tick();
        chk("mark_strobes", 32'({wr_mem, mem_din, rd_mem}), 32'b110);
        tick();
        chk("probe_up", 32'({rd_mem, inc_counter, adder_sel, inc_dec_sel, x_sel, y_sel}), 32'b110001);
        run_to_end(2000);
        chk("open_done", 32'(done), 32'd1);
        chk("open_fail", 32'(fail), 32'd0);
        chk("open_push_left", 32'(exp_push.size()), 32'd0);
        chk("open_pops", 32'(n_pop), 32'd0);
        tick();
        chk("done_held", 32'(done), 32'd1);
        go_idle();

        // Dead end: corridor (0,0)-(2,0), backtrack twice, then an empty stack fails
        w = '1;
        w[0] = 1'b0;
        w[1] = 1'b0;
        w[2] = 1'b0;
        load_maze(w);
        exp_push.delete();
        exp_pop.delete();
        exp_push.push_back(2'b01);
        exp_push.push_back(2'b01);
        exp_pop.push_back(2'b01);
        exp_pop.push_back(2'b01);
        begin_run();
        start = 1'b0;
        run_to_end(500);
        chk("dead_fail", 32'(fail), 32'd1);
        chk("dead_done", 32'(done), 32'd0);
        chk("dead_pushes", 32'(n_push), 32'd2);
        chk("dead_pops", 32'(n_pop), 32'd2);
        chk("dead_pop_left", 32'(exp_pop.size()), 32'd0);
        go_idle();

        // Enclosed start: four walled probes and no stack traffic
        w = '0;
        w[1] = 1'b1;
        w[16] = 1'b1;
        load_maze(w);
        exp_push.delete();
        exp_pop.delete();
        begin_run();
        start = 1'b0;
        run_to_end(500);
        chk("encl_fail", 32'(fail), 32'd1);
        chk("encl_done", 32'(done), 32'd0);
        chk("encl_probes", 32'(n_rd), 32'd4);
        chk("encl_push_pop", 32'(n_push + n_pop), 32'd0);
        go_idle();

        // Watchdog: limit 20 busy cycles on an endless corridor
        s18 = '0;
        s19 = '1;
        start_w = 1'b1;
        tick();
        start_w = 1'b0;
        n = 0;
        while (!fail_w && n < 100) begin
            tick();
            n++;
            if (n == 18) s18 = sw;
            if (n == 19) s19 = sw;
        end
        chk("wd_latency", 32'(n), 32'd20);
        chk("wd_pre_busy", 32'(s18[11]), 32'd1);
        chk("wd_hit_strobes", 32'(s19), 32'd0);
        tick();
        chk("wd_after_strobes", 32'(sw), 32'd0);
        chk("wd_fail_held", 32'({done_w, fail_w}), 32'b01);

        // Reset mid-run while in CHECK, then restart with start held high
        load_maze('0);
        exp_push.delete();
        exp_pop.delete();
        begin_run();
        start = 1'b0;
        tick();
        tick();
        chk("abort_in_check", 32'(rd_mem), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_async_outputs", 32'(so), 32'd0);
        #1;
        rst = 1'b1;
        tick();
        chk("abort_idle", 32'(so), 32'd0);
        load_maze('0);
        fill_open();
        begin_run();
        chk("restart_init", 32'({rst_reg, rst_counter}), 32'b11);
        run_to_end(2000);
        chk("held_done", 32'(done), 32'd1);
        chk("held_no_reinit", 32'(n_rstreg), 32'd1);
        chk("held_push_left", 32'(exp_push.size()), 32'd0);
        tick();
        chk("redo_done_drop", 32'(done), 32'd0);
        chk("redo_init", 32'({rst_reg, rst_counter}), 32'b11);
        start = 1'b0;
        go_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
